// File: rtl/edit_sequencer_pkg.sv
// rtl/edit_sequencer_pkg.sv - shared state encoding, field groups and decode helpers
package edit_sequencer_pkg;

    typedef enum logic [1:0] {
        RUN       = 2'd0,
        EDIT_CLK  = 2'd1,
        EDIT_DATE = 2'd2,
        EDIT_DSET = 2'd3
    } state_t;

    localparam int FIELD_W    = 4;
    localparam int NUM_FIELDS = 15;

    localparam logic [FIELD_W-1:0] CLK_BASE  = 4'd0;
    localparam logic [FIELD_W-1:0] CLK_LAST  = 4'd2;
    localparam logic [FIELD_W-1:0] DATE_BASE = 4'd3;
    localparam logic [FIELD_W-1:0] DATE_LAST = 4'd8;
    localparam logic [FIELD_W-1:0] DSET_BASE = 4'd9;
    localparam logic [FIELD_W-1:0] DSET_LAST = 4'd14;

    // First field index of the group edited in state s (0 in RUN).
    function automatic logic [FIELD_W-1:0] group_base(state_t s);
        case (s)
            EDIT_CLK:  return CLK_BASE;
            EDIT_DATE: return DATE_BASE;
            EDIT_DSET: return DSET_BASE;
            default:   return 4'd0;
        endcase
    endfunction

    // Last field index of the group edited in state s (0 in RUN).
    function automatic logic [FIELD_W-1:0] group_last(state_t s);
        case (s)
            EDIT_CLK:  return CLK_LAST;
            EDIT_DATE: return DATE_LAST;
            EDIT_DSET: return DSET_LAST;
            default:   return 4'd0;
        endcase
    endfunction

    // Mode key cycles RUN -> CLK -> DATE -> DSET -> RUN.
    function automatic state_t next_mode(state_t s);
        case (s)
            RUN:       return EDIT_CLK;
            EDIT_CLK:  return EDIT_DATE;
            EDIT_DATE: return EDIT_DSET;
            default:   return RUN;
        endcase
    endfunction

    // Group enable for the counter blocks: [0] clock, [1] date, [2] dset.
    function automatic logic [2:0] set_decode(state_t s);
        case (s)
            EDIT_CLK:  return 3'b001;
            EDIT_DATE: return 3'b010;
            EDIT_DSET: return 3'b100;
            default:   return 3'b000;
        endcase
    endfunction

    function automatic logic [NUM_FIELDS-1:0] field_onehot(logic [FIELD_W-1:0] f);
        return 15'd1 << f;
    endfunction

endpackage

// File: rtl/edit_sequencer_key_edge_repeat.sv
// rtl/edit_sequencer_key_edge_repeat.sv - rising-edge detect plus hold-to-repeat for one key
//
// Ports:
//   clk, reset  : clock, synchronous active-high reset
//   key         : debounced key level, 1 = pressed
//   tick        : single-cycle repeat-rate strobe
//   enable      : repeat counting allowed (editor is in an edit state)
//   clear       : editor state or field is changing this cycle
//   rise        : combinational rising edge of key
//   rep_pulse   : combinational auto-repeat request, one per tick once held long enough
module key_edge_repeat #(
    parameter int HOLD_TICKS = 2,
    parameter int CNT_W      = 7
) (
    input  logic clk,
    input  logic reset,
    input  logic key,
    input  logic tick,
    input  logic enable,
    input  logic clear,
    output logic rise,
    output logic rep_pulse
);

    logic             prev;
    logic [CNT_W-1:0] hold_cnt;
    logic             hold_done;

    assign hold_done = (hold_cnt == CNT_W'(HOLD_TICKS));
    assign rise      = key & ~prev;
    assign rep_pulse = key & enable & ~clear & tick & hold_done;

    // prev resets to 1 so a key held through reset does not look like a new press.
    always_ff @(posedge clk) begin
        if (reset) begin
            prev     <= 1'b1;
            hold_cnt <= '0;
        end else begin
            prev <= key;
            if (!key || !enable || clear) begin
                hold_cnt <= '0;
            end else if (tick && !hold_done) begin
                hold_cnt <= hold_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/edit_sequencer.sv
// rtl/edit_sequencer.sv - keyboard-driven edit controller for the calendar datapath
//
// Ports:
//   CLOCK_50  : system clock
//   reset     : synchronous active-high reset
//   tick_4hz  : single-cycle 4 Hz strobe
//   key_mode, key_next, key_up : debounced key levels, 1 = pressed
//   set[2:0]      : group edit enable, [0] clock, [1] date, [2] dset
//   up[14:0]      : single-cycle increment pulse for the selected field
//   select[14:0]  : one-hot field being edited, 0 in RUN
//   editing       : high whenever not in RUN
module edit_sequencer
    import edit_sequencer_pkg::*;
#(
    parameter int HOLD_TICKS    = 2,
    parameter int TIMEOUT_TICKS = 120,
    parameter int CNT_W         = 7
) (
    input  logic        CLOCK_50,
    input  logic        reset,
    input  logic        tick_4hz,
    input  logic        key_mode,
    input  logic        key_next,
    input  logic        key_up,
    output logic [2:0]  set,
    output logic [14:0] up,
    output logic [14:0] select,
    output logic        editing
);

    state_t               state_q, state_d;
    logic [FIELD_W-1:0]   field_q, field_d;
    logic [CNT_W-1:0]     to_cnt_q, to_cnt_d;
    logic                 prev_mode, prev_next;
    logic                 rise_mode, rise_next, rise_up, rep_up;
    logic                 in_edit, timed_out, changed, up_fire;

    assign rise_mode = key_mode & ~prev_mode;
    assign rise_next = key_next & ~prev_next;
    assign in_edit   = (state_q != RUN);
    assign timed_out = in_edit && (to_cnt_q == CNT_W'(TIMEOUT_TICKS));

    key_edge_repeat #(
        .HOLD_TICKS (HOLD_TICKS),
        .CNT_W      (CNT_W)
    ) u_key_up (
        .clk       (CLOCK_50),
        .reset     (reset),
        .key       (key_up),
        .tick      (tick_4hz),
        .enable    (in_edit),
        .clear     (changed),
        .rise      (rise_up),
        .rep_pulse (rep_up)
    );

    // Next state/field. Mode beats next; a pending timeout yields to any key
    // edge, including an up edge, which instead refreshes the timeout.
    always_comb begin
        state_d = state_q;
        field_d = field_q;
        if (rise_mode) begin
            state_d = next_mode(state_q);
            field_d = group_base(next_mode(state_q));
        end else if (in_edit && rise_next) begin
            field_d = (field_q == group_last(state_q)) ? group_base(state_q)
                                                       : field_q + 4'd1;
        end else if (timed_out && !rise_up) begin
            state_d = RUN;
            field_d = '0;
        end
    end

    assign changed = (state_d != state_q) || (field_d != field_q);

    // Up requests are dropped, not deferred, when a higher-priority event wins.
    always_comb begin
        up_fire = in_edit && !changed && !rise_mode && !rise_next && (rise_up || rep_up);
    end

    always_comb begin
        to_cnt_d = to_cnt_q;
        if (rise_mode || rise_next || rise_up || (state_d != state_q)) begin
            to_cnt_d = '0;
        end else if (in_edit && tick_4hz) begin
            to_cnt_d = to_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state_q   <= RUN;
            field_q   <= '0;
            to_cnt_q  <= '0;
            prev_mode <= 1'b1;
            prev_next <= 1'b1;
            set       <= '0;
            up        <= '0;
            select    <= '0;
            editing   <= 1'b0;
        end else begin
            state_q   <= state_d;
            field_q   <= field_d;
            to_cnt_q  <= to_cnt_d;
            prev_mode <= key_mode;
            prev_next <= key_next;
            set       <= set_decode(state_d);
            select    <= (state_d != RUN) ? field_onehot(field_d) : '0;
            editing   <= (state_d != RUN);
            // field is stable whenever up_fire is set, so up stays within select.
            up        <= up_fire ? field_onehot(field_q) : '0;
        end
    end

endmodule

// File: tb/tb_edit_sequencer.sv
// tb/tb_edit_sequencer.sv - directed self-checking bench for edit_sequencer
module tb_edit_sequencer;

    logic        CLOCK_50 = 1'b0;
    logic        reset;
    logic        tick_4hz;
    logic        key_mode;
    logic        key_next;
    logic        key_up;
    logic [2:0]  set;
    logic [14:0] up;
    logic [14:0] select;
    logic        editing;

    int n_cmp = 0;
    int n_bad = 0;

    always #10 CLOCK_50 = ~CLOCK_50;

    edit_sequencer dut (
        .CLOCK_50 (CLOCK_50),
        .reset    (reset),
        .tick_4hz (tick_4hz),
        .key_mode (key_mode),
        .key_next (key_next),
        .key_up   (key_up),
        .set      (set),
        .up       (up),
        .select   (select),
        .editing  (editing)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge CLOCK_50);
        #1;
    endtask

    task automatic press_mode();
        key_mode = 1'b1;
        step();
        key_mode = 1'b0;
        step();
    endtask

    task automatic tick_once();
        tick_4hz = 1'b1;
        step();
        tick_4hz = 1'b0;
        step();
    endtask

    logic [2:0]  exp_set [4] = '{3'b001, 3'b010, 3'b100, 3'b000};
    logic [14:0] exp_sel [4] = '{15'h0001, 15'h0008, 15'h0200, 15'h0000};
    logic        exp_ed  [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
    logic [14:0] exp_wrap[6] = '{15'h0010, 15'h0020, 15'h0040, 15'h0080, 15'h0100, 15'h0008};

    initial begin
        int pulses;
        int stray;

        reset = 1'b1; tick_4hz = 1'b0; key_mode = 1'b0; key_next = 1'b0; key_up = 1'b0;
        step();
        step();
        reset = 1'b0;
        step();
        check_eq("reset_set", set, 3'b000);
        check_eq("reset_select", select, 15'h0);
        check_eq("reset_up", up, 15'h0);
        check_eq("reset_editing", editing, 1'b0);

        // Mode cycling
        for (int i = 0; i < 4; i++) begin
            key_mode = 1'b1;
            step();
            check_eq($sformatf("mode%0d_set", i), set, exp_set[i]);
            check_eq($sformatf("mode%0d_select", i), select, exp_sel[i]);
            check_eq($sformatf("mode%0d_editing", i), editing, exp_ed[i]);
            key_mode = 1'b0;
            step();
        end

        // key_next ignored in RUN
        key_next = 1'b1;
        step();
        check_eq("run_next_select", select, 15'h0);
        key_next = 1'b0;
        step();

        // Field wrap in EDIT_DATE
        press_mode();
        press_mode();
        check_eq("date_entry_select", select, 15'h0008);
        for (int i = 0; i < 6; i++) begin
            key_next = 1'b1;
            step();
            check_eq($sformatf("wrap%0d_select", i), select, exp_wrap[i]);
            key_next = 1'b0;
            step();
        end

        // Single up pulse in EDIT_CLK field 1
        press_mode();
        press_mode();
        press_mode();
        key_next = 1'b1;
        step();
        key_next = 1'b0;
        step();
        check_eq("clk_f1_select", select, 15'h0002);
        pulses = 0;
        key_up = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            if (i == 0) check_eq("single_up_at_edge", up, 15'h0002);
            else if (up != 15'h0) pulses++;
        end
        check_eq("single_up_extra", pulses, 0);
        key_up = 1'b0;
        step();

        // No up pulses in RUN, even with ticks while held
        press_mode();
        press_mode();
        press_mode();
        check_eq("run_editing", editing, 1'b0);
        pulses = 0;
        key_up = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick_4hz = i[0];
            step();
            if (up != 15'h0) pulses++;
        end
        tick_4hz = 1'b0;
        key_up = 1'b0;
        step();
        check_eq("run_up_pulses", pulses, 0);

        // Auto-repeat in EDIT_DSET field 9
        press_mode();
        press_mode();
        press_mode();
        check_eq("dset_select", select, 15'h0200);
        key_up = 1'b1;
        step();
        check_eq("rep_edge", up, 15'h0200);
        stray = 0;
        for (int k = 1; k <= 6; k++) begin
            for (int j = 0; j < 3; j++) begin
                step();
                if (up != 15'h0) stray++;
            end
            tick_4hz = 1'b1;
            step();
            tick_4hz = 1'b0;
            check_eq($sformatf("rep_tick%0d", k), up, (k >= 3) ? 15'h0200 : 15'h0000);
        end
        step();
        check_eq("rep_stray", stray, 0);
        key_up = 1'b0;
        step();
        check_eq("rep_release", up, 15'h0);

        // Timeout from EDIT_DATE
        press_mode();
        press_mode();
        press_mode();
        check_eq("to_entry_set", set, 3'b010);
        for (int i = 0; i < 119; i++) tick_once();
        check_eq("to_119_set", set, 3'b010);
        tick_4hz = 1'b1;
        step();
        tick_4hz = 1'b0;
        check_eq("to_120_set", set, 3'b010);
        step();
        check_eq("to_done_set", set, 3'b000);
        check_eq("to_done_select", select, 15'h0);
        check_eq("to_done_editing", editing, 1'b0);

        // A key edge in the timeout cycle wins
        press_mode();
        for (int i = 0; i < 119; i++) tick_once();
        tick_4hz = 1'b1;
        step();
        tick_4hz = 1'b0;
        key_up = 1'b1;
        step();
        check_eq("to_edge_set", set, 3'b001);
        check_eq("to_edge_up", up, 15'h0001);
        key_up = 1'b0;
        step();
        step();
        check_eq("to_edge_still_edit", editing, 1'b1);

        // Mode and up rising together: mode wins, up dropped
        key_mode = 1'b1;
        key_up = 1'b1;
        step();
        check_eq("prio_set", set, 3'b010);
        check_eq("prio_select", select, 15'h0008);
        check_eq("prio_up", up, 15'h0);
        step();
        check_eq("prio_up_later", up, 15'h0);
        key_mode = 1'b0;
        key_up = 1'b0;
        step();

        // Reset mid-edit with key_up held
        press_mode();
        press_mode();
        press_mode();
        key_up = 1'b1;
        step();
        check_eq("rst_pre_up", up, 15'h0001);
        step();
        reset = 1'b1;
        step();
        check_eq("rst_set", set, 3'b000);
        check_eq("rst_up", up, 15'h0);
        check_eq("rst_select", select, 15'h0);
        check_eq("rst_editing", editing, 1'b0);
        reset = 1'b0;
        pulses = 0;
        for (int i = 0; i < 10; i++) begin
            tick_4hz = i[0];
            step();
            if (up != 15'h0) pulses++;
        end
        tick_4hz = 1'b0;
        check_eq("rst_held_pulses", pulses, 0);
        check_eq("rst_held_editing", editing, 1'b0);
        key_up = 1'b0;
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
